// File: rtl/regfile_dump.sv
// Sequential read-out engine: walks the register file read port and streams each word over valid/ready.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word (out_idx = 32) after the last register.
module regfile_dump #(
  parameter int NREGS  = 32,
  parameter int WORD_W = 32
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [4:0]        o_rsel,
  input  logic [WORD_W-1:0] i_rdat,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WORD_W-1:0] o_out_data,
  output logic [5:0]        o_out_idx,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM       = 3'd3;
  localparam logic [2:0] S_AFTER_LAST = S_CSUM;
  localparam logic [5:0] CSUM_IDX     = 6'd32;
`else
  localparam logic [2:0] S_AFTER_LAST = S_DONE;
`endif
  localparam logic [5:0] LAST_IDX = 6'(NREGS - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              w_nextValid;
  logic [5:0]        r_idx;
  logic [WORD_W-1:0] r_outData;
  logic [5:0]        r_outIdx;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;
`endif

  // Abort overrides every non-idle transition, including the handshake in SEND/CSUM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start && !i_abort) w_next = S_FETCH;
      S_FETCH: w_next = S_SEND;
      S_SEND:  if (i_out_ready) w_next = (r_idx == LAST_IDX) ? S_AFTER_LAST : S_FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM:  if (i_out_ready) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && i_abort) w_next = S_IDLE;

    w_nextValid = (w_next == S_SEND);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    if (w_next == S_CSUM) w_nextValid = 1'b1;
`endif
  end

  // Status outputs are decoded from the next state so they are plain flops.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state   <= S_IDLE;
      r_idx     <= 6'd0;
      r_outData <= '0;
      r_outIdx  <= 6'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_valid <= w_nextValid;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_next == S_FETCH) begin
            r_idx  <= 6'd0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (!i_abort) begin
            r_outData <= i_rdat;
            r_outIdx  <= r_idx;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum    <= r_csum ^ i_rdat;
`endif
          end
        end
        S_SEND: begin
          if (w_next == S_FETCH) r_idx <= r_idx + 6'd1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          if (w_next == S_CSUM) begin
            r_outData <= r_csum;
            r_outIdx  <= CSUM_IDX;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign o_rsel      = r_idx[4:0];
  assign o_out_valid = r_valid;
  assign o_out_data  = r_outData;
  assign o_out_idx   = r_outIdx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: cycle-table checks of a full dump plus hand-written corner sequences.
// Honours REGFILE_DUMP_CHECKSUM_EN the same way the design does.
module tb_regfile_dump;

  typedef struct {
    int          cyc;
    logic        expValid;
    logic [5:0]  expIdx;
    logic [31:0] expData;
    logic        expDone;
    logic        expBusy;
  } vec_t;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int LAST_CYC = 67;
`else
  localparam int LAST_CYC = 66;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic [4:0]  rsel;
  logic [31:0] rdat;
  logic        outValid;
  logic [31:0] outData;
  logic [5:0]  outIdx;
  logic        busy;
  logic        done;

  logic [31:0] regMem [32];
  vec_t        vecs [$];
  int          compared = 0;
  int          mismatched = 0;
  int          cycle = 0;

  always #5 clk = ~clk;
  assign rdat = regMem[rsel];

  regfile_dump #(.NREGS(32), .WORD_W(32)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_abort(abort),
    .o_rsel(rsel), .i_rdat(rdat), .o_out_valid(outValid), .i_out_ready(ready),
    .o_out_data(outData), .o_out_idx(outIdx), .o_busy(busy), .o_done(done)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Pulses start so the following edge is edge 0; returns in cycle 1 (FETCH of word 0).
  task automatic applyStimulus();
    start = 1'b1;
    stepCycle();
    cycle = 1;
    start = 1'b0;
  endtask

  task automatic runToEnd(input int bound, output int dones, output logic sawCsum,
                          output logic [31:0] csumSeen);
    bit finished = 0;
    dones = 0;
    sawCsum = 1'b0;
    csumSeen = '0;
    for (int k = 0; k < bound; k++) begin
      stepCycle();
      if (done) dones++;
      if (outValid && outIdx == 6'd32) begin
        sawCsum = 1'b1;
        csumSeen = outData;
      end
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    if (!finished) checkOutput("dumpTimeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] expWord(input int i);
    return (i == 0) ? 32'h0 : 32'h100 + i;
  endfunction

  initial begin
    int          vi;
    int          dones;
    logic        sawCsum;
    logic [31:0] csumSeen;

    for (int i = 0; i < 32; i++) regMem[i] = expWord(i);

    vecs.push_back('{1,  1'b0, 6'd0,  32'h0,   1'b0, 1'b1});
    vecs.push_back('{2,  1'b1, 6'd0,  32'h0,   1'b0, 1'b1});
    vecs.push_back('{3,  1'b0, 6'd0,  32'h0,   1'b0, 1'b1});
    vecs.push_back('{4,  1'b1, 6'd1,  32'h101, 1'b0, 1'b1});
    vecs.push_back('{12, 1'b1, 6'd5,  32'h105, 1'b0, 1'b1});
    vecs.push_back('{40, 1'b1, 6'd19, 32'h113, 1'b0, 1'b1});
    vecs.push_back('{64, 1'b1, 6'd31, 32'h11F, 1'b0, 1'b1});
`ifdef REGFILE_DUMP_CHECKSUM_EN
    vecs.push_back('{65, 1'b1, 6'd32, 32'h100, 1'b0, 1'b1});
    vecs.push_back('{66, 1'b0, 6'd0,  32'h0,   1'b1, 1'b1});
    vecs.push_back('{67, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0});
`else
    vecs.push_back('{65, 1'b0, 6'd0,  32'h0,   1'b1, 1'b1});
    vecs.push_back('{66, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0});
`endif

    // Reset held with start high: everything zero, and no dump afterwards without a new start.
    nrst = 1'b0;
    start = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("rstValid", {31'd0, outValid}, 32'd0);
    checkOutput("rstData", outData, 32'd0);
    checkOutput("rstIdx", {26'd0, outIdx}, 32'd0);
    checkOutput("rstRsel", {27'd0, rsel}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    start = 1'b0;
    nrst = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("postRstBusy", {31'd0, busy}, 32'd0);

    // Full dump with ready held high, checked against the cycle table.
    ready = 1'b1;
    applyStimulus();
    checkOutput("fetch0Rsel", {27'd0, rsel}, 32'd0);
    vi = 0;
    for (int c = 1; c <= LAST_CYC; c++) begin
      if (c > 1) stepCycle();
      if (c == 3) checkOutput("fetch1Rsel", {27'd0, rsel}, 32'd1);
      if (c % 2 == 0 && c <= 64) begin
        checkOutput("wordValid", {31'd0, outValid}, 32'd1);
        checkOutput("wordIdx", {26'd0, outIdx}, (c - 2) / 2);
        checkOutput("wordData", outData, expWord((c - 2) / 2));
      end
      if (vi < vecs.size() && vecs[vi].cyc == c) begin
        checkOutput("vecBusy", {31'd0, busy}, {31'd0, vecs[vi].expBusy});
        checkOutput("vecDone", {31'd0, done}, {31'd0, vecs[vi].expDone});
        checkOutput("vecValid", {31'd0, outValid}, {31'd0, vecs[vi].expValid});
        if (vecs[vi].expValid) begin
          checkOutput("vecIdx", {26'd0, outIdx}, {26'd0, vecs[vi].expIdx});
          checkOutput("vecData", outData, vecs[vi].expData);
        end
        vi++;
      end
    end
    checkOutput("vecCount", vi, vecs.size());

    // Backpressure on word 5 for three cycles; word 6 two cycles after ready returns.
    applyStimulus();
    while (cycle < 12) stepCycle();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("bpValid", {31'd0, outValid}, 32'd1);
      checkOutput("bpData", outData, 32'h105);
      checkOutput("bpIdx", {26'd0, outIdx}, 32'd5);
    end
    ready = 1'b1;
    stepCycle();
    checkOutput("bpGapValid", {31'd0, outValid}, 32'd0);
    stepCycle();
    checkOutput("bpWord6Valid", {31'd0, outValid}, 32'd1);
    checkOutput("bpWord6Data", outData, 32'h106);
    runToEnd(200, dones, sawCsum, csumSeen);
    checkOutput("bpDones", dones, 32'd1);

    // Abort while word 10 is presented: no transfer, no done.
    applyStimulus();
    while (cycle < 22) stepCycle();
    checkOutput("abWord10", outData, 32'h10A);
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("abBusy", {31'd0, busy}, 32'd0);
    checkOutput("abValid", {31'd0, outValid}, 32'd0);
    checkOutput("abDone", {31'd0, done}, 32'd0);
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      if (done) dones++;
    end
    checkOutput("abNoDone", dones, 32'd0);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startAbortBusy", {31'd0, busy}, 32'd0);

    // Fresh start after abort begins at register 0 and the checksum starts over.
    applyStimulus();
    stepCycle();
    checkOutput("reIdx", {26'd0, outIdx}, 32'd0);
    checkOutput("reData", outData, 32'd0);
    runToEnd(200, dones, sawCsum, csumSeen);
    checkOutput("reDones", dones, 32'd1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    checkOutput("reSawCsum", {31'd0, sawCsum}, 32'd1);
    checkOutput("reCsum", csumSeen, 32'h100);
`else
    checkOutput("reNoCsum", {31'd0, sawCsum}, 32'd0);
`endif

    // Start pulsed while word 3 is presented is ignored.
    applyStimulus();
    while (cycle < 8) stepCycle();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    stepCycle();
    checkOutput("sbIdx", {26'd0, outIdx}, 32'd4);
    checkOutput("sbData", outData, 32'h104);
    runToEnd(200, dones, sawCsum, csumSeen);
    checkOutput("sbDones", dones, 32'd1);

    // Register 20 written during the FETCH of word 12 shows up in word 20.
    applyStimulus();
    while (cycle < 25) stepCycle();
    regMem[20] = 32'hDEADBEEF;
    while (cycle < 42) stepCycle();
    checkOutput("mwIdx", {26'd0, outIdx}, 32'd20);
    checkOutput("mwData", outData, 32'hDEADBEEF);
    runToEnd(200, dones, sawCsum, csumSeen);
    regMem[20] = expWord(20);

    // Reset in the middle of a dump.
    applyStimulus();
    while (cycle < 10) stepCycle();
    nrst = 1'b0;
    stepCycle();
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("midRstValid", {31'd0, outValid}, 32'd0);
    checkOutput("midRstData", outData, 32'd0);
    checkOutput("midRstRsel", {27'd0, rsel}, 32'd0);
    nrst = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("midRstIdle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for the 32×32 register file. It sits on the read-port side of the register file. On a `start` pulse it walks `rsel` from register 0 to register 31 and captures each `rdat`. Each captured word is streamed out over a valid/ready handshake for debug, trace or checkpoint logic. Optionally it appends an XOR checksum word.

## Interface
- `NREGS`, default 32: number of registers dumped, indices 0..NREGS-1.
- `WORD_W`, default 32: register width in bits.
- `CLK`, in, 1: clock; all state updates on the rising edge.
- `nRST`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a dump; sampled only in IDLE.
- `abort`, in, 1: cancel an in-progress dump.
- `rsel`, out, 5: drives the register file read select.
- `rdat`, in, WORD_W: register file read data for `rsel`, combinational.
- `out_valid`, out, 1: `out_data`/`out_idx` hold a word.
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, WORD_W: dumped word.
- `out_idx`, out, 6: register index 0..31; 32 marks the checksum word.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse after the final word is accepted.

## Operation
- FSM states: IDLE, FETCH, SEND, CSUM, DONE.
- **IDLE**
  - `start`=1 and `abort`=0: clear idx and checksum, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - `rsel`=idx.
  - At the clock edge: `out_data`<=`rdat`, `out_idx`<=idx, checksum<=checksum ^ `rdat`, go to SEND.
- **SEND**
  - `out_valid`=1.
  - `out_ready`=0: hold, with `out_data` and `out_idx` stable.
  - `out_ready`=1 and idx<NREGS-1: idx<=idx+1, go to FETCH.
  - `out_ready`=1 and idx=NREGS-1: go to CSUM if the checksum is compiled in, else go to DONE.
- **CSUM**
  - `out_valid`=1, `out_data`=checksum, `out_idx`=32.
  - Hold until `out_ready`, then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **Abort**
  - `abort`=1 in any non-IDLE state: next state is IDLE, `out_valid` drops, and `done` is not pulsed.
  - A word presented in the same cycle as `abort` counts as not transferred.
- **Start while busy:** `start` outside IDLE is ignored.
- **Start and abort together in IDLE:** `abort` wins and the block stays in IDLE.
- **Reset:** `nRST`=0 at an edge returns to IDLE from any state, mid-dump included. All outputs go to their reset values at that edge.
  - state=IDLE, idx=0, checksum=0.
  - `rsel`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `busy`=0, `done`=0.
- **Coherence:** the dump is not atomic. Each register is sampled at the rising edge that ends its FETCH cycle, so it reflects any register file write completed before that edge.
- **Register 0** is dumped as read; it is 0 by construction of the register file.
- **Width rules:** idx is 6 bits and never wraps; the checksum is the WORD_W-bit XOR of all captured words.

## Timing
- Let `start` be sampled at edge 0.
- FETCH occupies cycle 1; word 0 is valid from cycle 2.
- With `out_ready` held at 1, each word takes 2 cycles: word i is valid in cycle 2+2i.
  - Word 31 is valid in cycle 64.
  - Checksum disabled: `done`=1 in cycle 65, IDLE in cycle 66.
  - Checksum enabled: checksum valid in cycle 65, `done` in cycle 66, IDLE in cycle 67.
- `out_valid` and `done` are registered outputs; they have no combinational path from `out_ready`.
- `rsel` changes only on rising edges and is stable for the whole FETCH cycle.

## Configuration
- Macro: `REGFILE_DUMP_CHECKSUM_EN`.
- Defined: the CSUM state exists, and one extra word with `out_idx`=32 follows register 31.
- Undefined: CSUM and the checksum register are removed, SEND goes straight to DONE, and `out_idx` never reaches 32.

## Test plan
- **Reset values:** hold `nRST`=0 for 2 cycles with `start`=1 -> all outputs 0 and `busy`=0; still IDLE after `nRST` rises until `start` is sampled again.
- **Full dump, no backpressure:** preload reg[i]=0x100+i for i≥1, reg0=0; `out_ready`=1, pulse `start` -> 32 words, word i = 0x100+i (word 0 = 0) at cycle 2+2i.
  - Checksum disabled: `done` at cycle 65.
  - Checksum enabled: checksum word 0x00000100 with `out_idx`=32 at cycle 65, `done` at cycle 66.
- **Backpressure:** drop `out_ready` for 3 cycles while word 5 is valid -> `out_data`=0x105 and `out_idx`=5 held stable; word 6 follows 2 cycles after `out_ready` returns.
- **Abort:** assert `abort` while word 10 is valid -> next cycle `busy`=0, `out_valid`=0, no `done`. A fresh `start` restarts at reg0, and the checksum restarts from 0.
- **Start while busy:** pulse `start` at word 3 -> ignored; the dump continues unchanged and exactly one `done` is produced.
- **Mid-dump write:** write reg20=0xDEADBEEF during the FETCH of word 12 -> word 20 reads 0xDEADBEEF.
